// File: rtl/vec_operand_loader.sv
// Fetches LANES half-precision words, one read at a time, and packs them into a vector operand.
// Optional VEC_LOADER_STRIDE_EN adds a per-lane address stride input (default build steps by 1).
module vec_operand_loader #(
  parameter int ADDR_W = 16,
  parameter int LANES  = 16,
  parameter int LANE_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
`ifdef VEC_LOADER_STRIDE_EN
  input  logic [ADDR_W-1:0]       stride,
`endif
  output logic                    busy,
  output logic                    mem_re,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [LANE_W-1:0]       mem_rdata,
  input  logic                    mem_rvalid,
  output logic [LANES*LANE_W-1:0] vec_data,
  output logic                    vec_valid,
  input  logic                    vec_ready
);

  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   lane_cnt;
  logic [ADDR_W-1:0]  addr_reg;
  logic [ADDR_W-1:0]  step;
  logic               lane_wr;
  logic [LANE_W-1:0]  lane_reg [LANES];

`ifdef VEC_LOADER_STRIDE_EN
  logic [ADDR_W-1:0]  stride_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stride_reg <= '0;
    end else if (state == IDLE && start) begin
      stride_reg <= stride;
    end
  end

  assign step = stride_reg;
`else
  assign step = ADDR_W'(1);
`endif

  // The address register doubles as the memory address; it only changes outside REQ.
  assign mem_addr = addr_reg;
  assign lane_wr  = (state == WAIT) && mem_rvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lane_cnt  <= '0;
      addr_reg  <= '0;
      mem_re    <= 1'b0;
      vec_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr_reg <= base_addr;
            lane_cnt <= '0;
            mem_re   <= 1'b1;
            busy     <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          mem_re <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          if (mem_rvalid) begin
            if (lane_cnt == LAST_LANE) begin
              vec_valid <= 1'b1;
              state     <= DONE;
            end else begin
              lane_cnt <= lane_cnt + CNT_W'(1);
              addr_reg <= addr_reg + step;
              mem_re   <= 1'b1;
              state    <= REQ;
            end
          end
        end
        DONE: begin
          if (vec_ready) begin
            vec_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          mem_re    <= 1'b0;
          vec_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Lanes are overwritten in place; stale contents are only visible while vec_valid is low.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lane_reg[gi] <= '0;
        end else if (lane_wr && lane_cnt == CNT_W'(gi)) begin
          lane_reg[gi] <= mem_rdata;
        end
      end
      assign vec_data[gi*LANE_W +: LANE_W] = lane_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_vec_operand_loader.sv
// Self-checking bench for vec_operand_loader: random-latency memory responder plus a
// reference vector computed directly from memory contents and the address rule.
module tb_vec_operand_loader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [15:0]  base_addr = '0;
`ifdef VEC_LOADER_STRIDE_EN
  logic [15:0]  stride = '0;
`endif
  logic         busy;
  logic         mem_re;
  logic [15:0]  mem_addr;
  logic [15:0]  mem_rdata = '0;
  logic         mem_rvalid = 1'b0;
  logic [255:0] vec_data;
  logic         vec_valid;
  logic         vec_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [15:0]  mem [0:65535];
  logic [15:0]  addr_q [$];
  int           lat_max = 1;
  int           pend_cnt = 0;
  bit           pend = 1'b0;
  logic [15:0]  pend_addr = '0;

  vec_operand_loader dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .base_addr(base_addr),
`ifdef VEC_LOADER_STRIDE_EN
    .stride(stride),
`endif
    .busy(busy),
    .mem_re(mem_re),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid),
    .vec_data(vec_data),
    .vec_valid(vec_valid),
    .vec_ready(vec_ready)
  );

  always #5 clk = ~clk;

  // Memory responder and request monitor: one outstanding read, 1..lat_max cycles of latency.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend       = 1'b0;
      mem_rvalid = 1'b0;
    end else begin
      mem_rvalid = 1'b0;
      if (pend) begin
        if (pend_cnt <= 1) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem[pend_addr];
          pend       = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      if (mem_re) begin
        addr_q.push_back(mem_addr);
        pend      = 1'b1;
        pend_cnt  = $urandom_range(1, lat_max);
        pend_addr = mem_addr;
      end
    end
  end

  task automatic run_load(input logic [15:0] base, input logic [15:0] str, input int lat,
                          input int hold, input bit ready_early, input bit chk_lat,
                          input string tag);
    logic [255:0] exp_vec;
    logic [15:0]  a;
    int           edges;
    int           bad;
    begin
      lat_max = lat;
      for (int i = 0; i < 16; i++) begin
        a = base + 16'(i) * str;
        exp_vec[i*16 +: 16] = mem[a];
      end
      addr_q.delete();
      @(negedge clk);
      start = 1'b1;
      base_addr = base;
`ifdef VEC_LOADER_STRIDE_EN
      stride = str;
`endif
      vec_ready = ready_early;
      @(negedge clk);
      start = 1'b0;
      edges = 0;
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy_after_start: got %b want 1", tag, busy);
      end
      while (!vec_valid && edges < 3000) begin
        @(negedge clk);
        edges++;
      end
      checks++;
      if (vec_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s vec_valid_timeout: got %b want 1 after %0d edges", tag, vec_valid, edges);
      end
      if (chk_lat) begin
        checks++;
        if (edges != 32) begin
          errors++;
          $display("FAIL %s latency: got %0d edges want 32", tag, edges);
        end
      end
      checks++;
      if (vec_data !== exp_vec) begin
        errors++;
        $display("FAIL %s vec_data: got %h want %h", tag, vec_data, exp_vec);
      end
      bad = (addr_q.size() != 16) ? 1 : 0;
      for (int i = 0; i < addr_q.size() && i < 16; i++) begin
        a = base + 16'(i) * str;
        if (addr_q[i] !== a) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL %s addresses: got %0d reads, first %h, want 16 reads from %h step %h",
                 tag, addr_q.size(), (addr_q.size() > 0) ? addr_q[0] : 16'h0, base, str);
      end
      for (int h = 0; h < hold; h++) begin
        start = (h == 2);
        base_addr = $urandom;
        checks++;
        if (vec_valid !== 1'b1 || vec_data !== exp_vec || mem_re !== 1'b0) begin
          errors++;
          $display("FAIL %s backpressure_hold[%0d]: got valid=%b re=%b data=%h want valid=1 re=0 data=%h",
                   tag, h, vec_valid, mem_re, vec_data, exp_vec);
        end
        @(negedge clk);
      end
      vec_ready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      vec_ready = 1'b0;
      checks++;
      if (vec_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s handshake_return: got valid=%b busy=%b want 0 0", tag, vec_valid, busy);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (addr_q.size() != 16 || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s no_new_load: got %0d reads busy=%b want 16 reads busy=0",
                 tag, addr_q.size(), busy);
      end
      $display("load %s base=%h stride=%h lat<=%0d edges=%0d data=%h", tag, base, str, lat, edges, vec_data);
    end
  endtask

  task automatic test_reset();
    begin
      rst_n = 1'b0;
      repeat (3) begin
        @(negedge clk);
        checks++;
        if ({busy, mem_re, vec_valid} !== 3'b000 || mem_addr !== 16'h0 || vec_data !== '0) begin
          errors++;
          $display("FAIL reset_values: got busy=%b re=%b valid=%b addr=%h data=%h want all 0",
                   busy, mem_re, vec_valid, mem_addr, vec_data);
        end
      end
      rst_n = 1'b1;
      repeat (10) begin
        @(negedge clk);
        checks++;
        if ({busy, mem_re, vec_valid} !== 3'b000 || mem_addr !== 16'h0 || vec_data !== '0) begin
          errors++;
          $display("FAIL idle_values: got busy=%b re=%b valid=%b addr=%h data=%h want all 0",
                   busy, mem_re, vec_valid, mem_addr, vec_data);
        end
      end
      $display("reset: 3 cycles low then 10 idle cycles");
    end
  endtask

  task automatic test_basic();
    begin
      for (int i = 0; i < 16; i++) mem[16'h0100 + i] = 16'h3C00 + 16'(i);
      run_load(16'h0100, 16'h0001, 1, 0, 1'b1, 1'b1, "basic");
    end
  endtask

  task automatic test_lane_ends();
    logic [15:0] lo;
    logic [15:0] hi;
    begin
      lo = vec_data[15:0];
      hi = vec_data[255:240];
      checks++;
      if (lo !== 16'h3C00 || hi !== 16'h3C0F) begin
        errors++;
        $display("FAIL basic_lane_ends: got lane0=%h lane15=%h want 3c00 3c0f", lo, hi);
      end
    end
  endtask

  task automatic test_backpressure();
    begin
      for (int k = 0; k < 3; k++)
        run_load(16'($urandom), 16'h0001, 4, 5, 1'b0, 1'b0, "backpressure");
    end
  endtask

  task automatic test_wrap();
    logic [15:0] l8;
    begin
      run_load(16'hFFF8, 16'h0001, 2, 1, 1'b0, 1'b0, "wrap");
      l8 = vec_data[8*16 +: 16];
      checks++;
      if (l8 !== mem[16'h0000]) begin
        errors++;
        $display("FAIL wrap_lane8: got %h want %h", l8, mem[16'h0000]);
      end
    end
  endtask

  task automatic test_reset_midload();
    int guard;
    begin
      lat_max = 1;
      addr_q.delete();
      @(negedge clk);
      start = 1'b1;
      base_addr = 16'h0400;
`ifdef VEC_LOADER_STRIDE_EN
      stride = 16'h0001;
`endif
      @(negedge clk);
      start = 1'b0;
      guard = 0;
      while (addr_q.size() < 8 && guard < 500) begin
        @(negedge clk);
        guard++;
      end
      checks++;
      if (addr_q.size() < 8) begin
        errors++;
        $display("FAIL midload_progress: got %0d reads want 8", addr_q.size());
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (mem_re !== 1'b0 || vec_valid !== 1'b0 || busy !== 1'b0 || vec_data !== '0) begin
        errors++;
        $display("FAIL midload_reset: got re=%b valid=%b busy=%b data=%h want 0 0 0 0",
                 mem_re, vec_valid, busy, vec_data);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      $display("reset mid-load after %0d reads", addr_q.size());
      run_load(16'($urandom), 16'h0001, 3, 2, 1'b0, 1'b0, "after_reset");
    end
  endtask

`ifdef VEC_LOADER_STRIDE_EN
  task automatic test_stride();
    logic [255:0] bcast;
    begin
      run_load(16'h0200, 16'h0004, 2, 1, 1'b0, 1'b0, "stride4");
      run_load(16'h0200, 16'h0000, 2, 1, 1'b0, 1'b0, "stride0");
      for (int i = 0; i < 16; i++) bcast[i*16 +: 16] = mem[16'h0200];
      checks++;
      if (vec_data !== bcast) begin
        errors++;
        $display("FAIL stride0_broadcast: got %h want %h", vec_data, bcast);
      end
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    test_reset();
    test_basic();
    test_lane_ends();
    test_backpressure();
    test_wrap();
    test_reset_midload();
`ifdef VEC_LOADER_STRIDE_EN
    test_stride();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
